// File: rtl/led_shift_pattern.sv
// led_shift_pattern
//   LED pattern engine running entirely in the clk domain. A prescaler
//   produces a one-cycle tick enable every DIV = CLK_HZ/TICK_HZ cycles.
//   A divide-by-PERIOD phase generator produces `pattern` (high in phase 0).
//   A WIDTH-bit shift register either shifts `pattern` in or rotates its own
//   contents once per tick, in either direction.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset (cnt, phase, q cleared)
//   restart     in   synchronous restart of prescaler and phase generator
//   pause       in   freezes phase and shift; prescaler keeps running
//   dir         in   0: shift toward MSB, 1: shift toward LSB
//   mode        in   0: shift in `pattern`, 1: rotate
//   load        in   parallel load strobe, highest priority on q
//   load_value  in   [WIDTH-1:0] value loaded into q
//   q           out  [WIDTH-1:0] LED vector, q[0] is the LED0 end
//   pattern     out  phase generator output, high while phase == 0
//   tick_o      out  one-cycle tick pulse (cnt == DIV-1)
module led_shift_pattern #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned PERIOD  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             pause,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             pattern,
  output logic             tick_o
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(PERIOD - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick;
  logic             adv;
  logic             pat;

  assign tick = (cnt_q == CNT_MAX);
  // restart and pause both block the advance; the tick itself stays visible.
  assign adv  = tick & ~restart & ~pause;
  assign pat  = (phase_q == '0);

  // Prescaler: free-running, only restart or wrap clears it.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Phase generator S0..S(PERIOD-1).
  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (adv) begin
      phase_d = (phase_q == PH_MAX) ? '0 : phase_q + PW'(1);
    end
  end

  // Shift register: load beats advance; the bit shifted in is the
  // pre-edge pattern.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_value;
    end else if (adv) begin
      unique case ({mode, dir})
        2'b00:   q_d = {q_q[WIDTH-2:0], pat};
        2'b01:   q_d = {pat, q_q[WIDTH-1:1]};
        2'b10:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        default: q_d = {q_q[0], q_q[WIDTH-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
      q_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      q_q     <= q_d;
    end
  end

  assign q       = q_q;
  assign pattern = pat;
  assign tick_o  = tick;

endmodule

// File: tb/tb_led_shift_pattern.sv
module tb_led_shift_pattern;

  localparam int unsigned W    = 5;
  localparam int unsigned DIV  = 4;
  localparam int unsigned PER  = 4;
  localparam int          QMOD = 32;   // 2**W
  localparam int          QTOP = 16;   // weight of the MSB

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b1;
  logic         restart    = 1'b0;
  logic         pause      = 1'b0;
  logic         dir        = 1'b0;
  logic         mode       = 1'b0;
  logic         load       = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] q;
  logic         pattern;
  logic         tick_o;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  led_shift_pattern #(
    .CLK_HZ (4),
    .TICK_HZ(1),
    .WIDTH  (W),
    .PERIOD (PER)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart),
    .pause     (pause),
    .dir       (dir),
    .mode      (mode),
    .load      (load),
    .load_value(load_value),
    .q         (q),
    .pattern   (pattern),
    .tick_o    (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: cycles since the last reset/restart, phase as an
  // integer mod PERIOD, LED vector as an integer mod 2**W.
  int m_n     = 0;
  int m_phase = 0;
  int m_q     = 0;
  bit m_tick, m_adv;
  int m_in, m_nq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n     <= 0;
      m_phase <= 0;
      m_q     <= 0;
    end else begin
      m_tick = (m_n % DIV) == DIV - 1;
      m_adv  = m_tick && !restart && !pause;
      m_in   = (m_phase == 0) ? 1 : 0;
      m_nq   = m_q;
      if (m_adv) begin
        if (!mode && !dir)     m_nq = (m_q * 2) % QMOD + m_in;
        else if (!mode && dir) m_nq = m_q / 2 + m_in * QTOP;
        else if (mode && !dir) m_nq = (m_q * 2) % QMOD + m_q / QTOP;
        else                   m_nq = m_q / 2 + (m_q % 2) * QTOP;
      end
      if (load) m_nq = int'(load_value);
      m_q <= m_nq;
      if (restart) begin
        m_n     <= 0;
        m_phase <= 0;
      end else begin
        m_n <= m_n + 1;
        if (m_adv) m_phase <= (m_phase + 1) % PER;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q", int'(q), m_q);
      check("model_pattern", int'(pattern), (m_phase == 0) ? 1 : 0);
      check("model_tick", int'(tick_o), ((m_n % DIV) == DIV - 1) ? 1 : 0);
    end
  end

  // All stimulus changes happen 1 time unit after a falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Stop in the current tick cycle (bounded).
  task automatic find_tick();
    bit found = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (tick_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check("tick_timeout", 0, 1);
  endtask

  // Stop one cycle after the next tick, where q/phase have updated.
  task automatic wait_tick();
    find_tick();
    step();
  endtask

  int exp2_q[5] = '{1, 2, 4, 8, 17};
  int exp2_p[5] = '{0, 0, 0, 1, 0};
  int exp3_q[5] = '{16, 8, 4, 2, 17};
  int exp4_q[4] = '{6, 12, 24, 17};
  int exp5_q[3] = '{10, 20, 9};

  initial begin
    int nt;
    int gap;

    // 1. reset and tick cadence
    #1 reset_n = 1'b0;
    step();
    chk_en = 1'b1;
    check("reset_q", int'(q), 0);
    check("reset_pattern", int'(pattern), 1);
    check("reset_tick", int'(tick_o), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("tick_cycle", int'(tick_o), (i % 4 == 3) ? 1 : 0);
      step();
    end

    // 2. mode 0, dir 0
    do_reset();
    mode = 1'b0; dir = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      check("m0d0_q", int'(q), exp2_q[k]);
      check("m0d0_pattern", int'(pattern), exp2_p[k]);
    end
    check("model_pin_m0d0", m_q, 17);

    // 3. mode 0, dir 1
    do_reset();
    dir = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      check("m0d1_q", int'(q), exp3_q[k]);
    end
    check("model_pin_m0d1", m_q, 17);

    // 4. rotate
    do_reset();
    mode = 1'b1; dir = 1'b0;
    load_value = 5'b00011; load = 1'b1;
    step();
    load = 1'b0;
    check("rot_load", int'(q), 3);
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      check("rot_left_q", int'(q), exp4_q[k]);
    end
    dir = 1'b1;
    wait_tick();
    check("rot_right_q", int'(q), 24);
    check("model_pin_rot", m_q, 24);

    // 5. pause, load under pause, resume
    do_reset();
    mode = 1'b0; dir = 1'b0;
    wait_tick();
    wait_tick();
    check("pre_pause_q", int'(q), 2);
    pause = 1'b1;
    nt = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (tick_o) nt++;
      check("pause_q", int'(q), 2);
      check("pause_pattern", int'(pattern), 0);
      step();
    end
    check("pause_tick_count", nt, 3);
    load_value = 5'b10101; load = 1'b1;
    step();
    load = 1'b0;
    check("pause_load", int'(q), 21);
    pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      check("resume_q", int'(q), exp5_q[k]);
    end

    // 6a. restart in a tick cycle with q=00100, phase=2
    do_reset();
    wait_tick();
    wait_tick();
    load_value = 5'b00100; load = 1'b1;
    step();
    load = 1'b0;
    find_tick();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_q", int'(q), 4);
    check("restart_pattern", int'(pattern), 1);
    check("restart_tick_low", int'(tick_o), 0);
    gap = 0;
    while (!tick_o && gap < 2 * DIV) begin
      step();
      gap++;
    end
    check("restart_tick_gap", gap, 3);
    step();
    check("after_restart_q", int'(q), 9);

    // 6b. asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("async_q", int'(q), 0);
    check("async_pattern", int'(pattern), 1);
    check("async_tick", int'(tick_o), 0);
    step();
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      restart    = ($urandom_range(0, 15) == 0);
      pause      = ($urandom_range(0, 3) == 0);
      load       = ($urandom_range(0, 7) == 0);
      load_value = W'($urandom);
      dir        = 1'($urandom);
      mode       = 1'($urandom);
      step();
    end
    restart = 1'b0; pause = 1'b0; load = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/led_shift_pattern.md
# led_shift_pattern

Parametrised LED pattern engine: a prescaler producing a one-cycle tick enable, a divide-by-PERIOD phase generator, and a WIDTH-bit shift register that moves the generated pulse (or rotates its own contents) across the board LEDs once per tick. It replaces the fixed 1 Hz / divide-by-4 / 5-LED chain. Everything runs in the single `clk` domain with a tick enable instead of a derived clock. It adds direction, rotate mode, pause, parallel load and a synchronous restart.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 1: tick rate. DIV = CLK_HZ/TICK_HZ, and DIV ≥ 2 is required.
- `WIDTH`, default 5: shift register / LED count. WIDTH ≥ 2.
- `PERIOD`, default 4: phase generator period. PERIOD ≥ 2.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous restart of the prescaler and phase generator.
- `pause`  in  1  freezes phase and shift while high.
- `dir`  in  1  0: shift toward MSB; 1: shift toward LSB.
- `mode`  in  1  0: shift in `pattern`; 1: rotate.
- `load`  in  1  parallel load strobe.
- `load_value`  in  WIDTH  value loaded into `q`.
- `q`  out  WIDTH  LED vector; `q[0]` is the LED0 end.
- `pattern`  out  1  phase generator output (FSM LED).
- `tick_o`  out  1  one-cycle tick pulse.

All control inputs are synchronous to `clk`. Synchronisation and debouncing are done upstream.

## Operation
- **Prescaler:** `cnt` counts 0..DIV-1 and wraps to 0. `tick_o = (cnt == DIV-1)`, combinational from the register. `cnt` width is $clog2(DIV).
- **Advance enable:** `adv = tick_o & ~restart & ~pause`.
- **Phase generator:** `phase` runs 0..PERIOD-1 and advances by 1 on `adv`, wrapping at PERIOD-1. States are S0..S(PERIOD-1); Sk→Sk+1 on `adv`. `pattern = (phase == 0)`.
- **Shift register, priority order:**
  1. `load`: `q <= load_value`. This applies regardless of tick, pause or restart.
  2. Else if `adv`:
     - mode 0, dir 0: `q <= {q[WIDTH-2:0], pattern}`
     - mode 0, dir 1: `q <= {pattern, q[WIDTH-1:1]}`
     - mode 1, dir 0: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`
     - mode 1, dir 1: `q <= {q[0], q[WIDTH-1:1]}`
  3. Else hold.
- The value shifted in is `pattern` from *before* the edge, i.e. the current phase.
- **restart:** `cnt <= 0` and `phase <= 0`. `q` is untouched, except that a shift is suppressed that cycle.
- **pause:** `cnt` keeps running and `tick_o` keeps pulsing. `phase` and `q` hold. `load` still works.
- **Reset (`reset_n` low, asynchronous):** `cnt = 0`, `phase = 0`, `q = 0`. Outputs are therefore `q = 0`, `pattern = 1`, `tick_o = 0`. This takes effect immediately, including mid-count or mid-shift.

## Timing
- After `reset_n` deasserts, the first `tick_o` is high during cycle DIV-1 (0-based), then every DIV cycles.
- `q` and `phase` update on the edge that ends a `tick_o` cycle, so they are visible one cycle after `tick_o`.
- `load` in cycle k gives `q = load_value` in cycle k+1.
- `restart` in cycle k gives `cnt = 0` and `phase = 0` in cycle k+1. The next tick comes DIV cycles after k.
- Simultaneous events:
  - `load` + `adv`: `q` takes `load_value`; `phase` still advances.
  - `restart` + tick: restart wins. No advance, no shift. `tick_o` is still visible high that cycle.
  - `pause` + `restart`: restart still clears `cnt` and `phase`.
- `dir` and `mode` are sampled only in `adv` cycles. Changing them between ticks has no effect until the next tick.

## Test plan
Common setup: CLK_HZ=4, TICK_HZ=1 (DIV=4), WIDTH=5, PERIOD=4.

1. **Reset:** hold `reset_n` low, then release. Required: `q=00000`, `pattern=1`, `tick_o=0`. `tick_o` is high in cycles 3, 7, 11…
2. **mode 0, dir 0 from reset, 5 ticks:** `q` after each tick = 00001, 00010, 00100, 01000, 10001. `pattern` after each tick = 0, 0, 0, 1, 0.
3. **mode 0, dir 1 from reset, 5 ticks:** `q` = 10000, 01000, 00100, 00010, 10001.
4. **mode 1, dir 0:** `load` with `load_value=00011`, then 4 ticks. `q` = 00110, 01100, 11000, 10001. Then switch to dir 1 and apply 1 tick: `q` = 11000.
5. **pause and load under pause:** assert `pause` across 3 ticks; `tick_o` keeps pulsing while `q` and `pattern` are frozen. `load` `10101` during pause gives `q=10101` next cycle. Releasing `pause` resumes from the frozen phase.
6. **Restart and asynchronous reset:**
   - Assert `restart` in a `tick_o` cycle with `q=00100`, `phase=2`. Required: `q` stays 00100, `phase=0`, and the next tick comes 4 cycles later.
   - Drop `reset_n` between clock edges mid-run. Required: `q=00000` and `pattern=1` immediately, without waiting for an edge.
